// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache between the fetch stage and
// the memory controller's line-fill port. Hits return in the same cycle from
// the line array; misses issue one line fill and install the returned line.
module icache_fetch #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 16,
   parameter int NUM_LINES  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rdy,
   input  logic                    rollback,
   input  logic                    fetch_en,
   input  logic [ADDR_W-1:0]       fetch_pc,
   output logic                    inst_valid,
   output logic [31:0]             fetch_inst,
   output logic                    mc_en,
   output logic [ADDR_W-1:0]       mc_pc,
   input  logic                    mc_done,
   input  logic [LINE_BYTES*8-1:0] mc_data
);

   localparam int OFF    = $clog2(LINE_BYTES);
   localparam int IDX    = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - OFF - IDX;
   localparam int LINE_W = LINE_BYTES * 8;

   // Clears the two byte-select bits so a word read is always aligned.
   localparam logic [OFF-1:0] WORD_MASK = ~OFF'(3);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t state;

   // Line storage: valid bits qualify the tag and data arrays.
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [LINE_W-1:0]    data_mem [NUM_LINES];

   // Lookup-side address split of the fetch pc.
   logic [OFF-1:0]   pc_off;
   logic [OFF-1:0]   word_off;
   logic [IDX-1:0]   pc_idx;
   logic [TAG_W-1:0] pc_tag;

   assign pc_off   = fetch_pc[OFF-1:0];
   assign pc_idx   = fetch_pc[OFF+IDX-1:OFF];
   assign pc_tag   = fetch_pc[ADDR_W-1:OFF+IDX];
   assign word_off = pc_off & WORD_MASK;

   // Fill-side address split of the outstanding request. The offset bits of
   // mc_pc are always zero, so they take no part in the install.
   logic [IDX-1:0]   fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             unused_fill_off;

   assign fill_idx        = mc_pc[OFF+IDX-1:OFF];
   assign fill_tag        = mc_pc[ADDR_W-1:OFF+IDX];
   assign unused_fill_off = ^mc_pc[OFF-1:0];

   // Lookup qualification. Hits are only possible in IDLE, so a hit and a
   // fill install can never coincide.
   logic             lookup_req;
   logic             tag_match;
   logic             hit;
   logic             miss;
   logic             fill_we;
   logic [LINE_W-1:0] lookup_line;
   logic [31:0]      lookup_word;

   assign lookup_req  = fetch_en && rdy && !rollback && (state == S_IDLE);
   assign tag_match   = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign hit         = lookup_req && tag_match;
   assign miss        = lookup_req && !tag_match;

   // A fill installs only when the controller completes while the cache is
   // waiting and the pipeline is not stalled; rollback does not cancel it.
   assign fill_we     = rdy && mc_done && (state == S_WAIT);

   // Little-endian word extraction: byte at word_off lands in bits [7:0].
   assign lookup_line = data_mem[pc_idx];
   assign lookup_word = lookup_line[{word_off, 3'b000} +: 32];

   assign inst_valid  = hit;
   assign fetch_inst  = hit ? lookup_word : 32'h0;

   // Fill controller: one outstanding request, held stable until mc_done.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignments so every branch below
      // sees the pre-edge values of state, mc_en and mc_pc.
      if (!rst_n) begin
         state <= S_IDLE;
         mc_en <= 1'b0;
         mc_pc <= '0;
      end else if (rdy) begin
         case (state)
            S_IDLE: begin
               if (miss) begin
                  mc_en <= 1'b1;
                  mc_pc <= {pc_tag, pc_idx, {OFF{1'b0}}};
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mc_done) begin
                  mc_en <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               mc_en <= 1'b0;
            end
         endcase
      end
   end

   // Valid bits: cleared by reset, set when a fill installs its line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (fill_we) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag and data arrays: written only by a completing fill.
   always_ff @(posedge clk) begin
      // NOTE: tag and data arrays carry no reset; valid_q alone decides
      // whether an entry is meaningful, so the arrays can map to plain RAM.
      if (fill_we) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mc_data;
      end
   end

endmodule
